// File: rtl/shift_pkg.sv
// Shared definitions for the parallel-in serial-out shifter.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package shift_pkg;

  // Bit order selected by the dir input and latched at load.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Transmit FSM: waiting for a word, or serialising one.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit counter width.
  // It holds MSB-1 down to 0, which always fits in $clog2(MSB) bits.
  function automatic int CNT_W(input int msb);
    return $clog2(msb);
  endfunction

endpackage

// File: rtl/piso_shift_reg_bit_cnt.sv
// Loadable down-counter with a zero flag; tracks bits left in the current word.
// Latency: load/decrement take effect on the next posedge; zero is combinational on the count.
// Backpressure: none; dec is only honoured while the count is non-zero, so it never wraps.
//
// Ports:
//   clk, rstn  clock and synchronous active-low reset (count clears to 0)
//   load       load load_val on the next edge (has priority over dec)
//   load_val   reload value
//   dec        decrement on the next edge
//   zero       count is 0
module bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: takes a word on a valid/ready handshake and emits it one bit per enabled clock.
// Latency: the first bit is on sout the cycle after the handshake; a word takes exactly MSB enabled cycles.
// Backpressure: load_ready is high in IDLE and, combinationally, on the final enabled bit only. en=0 stalls the shifter and freezes all outputs.
//
// Ports:
//   clk, rstn             clock and synchronous active-low reset
//   en                    shift enable (ignored in IDLE)
//   dir                   0 = MSB first, 1 = LSB first; latched with the word
//   load_valid/load_data  incoming word
//   load_ready            word can be accepted this cycle (0 while rstn=0)
//   sout/sout_valid       serial bit and its qualifier
//   last                  sout is the final bit of the word
//   busy                  a word is in flight
module piso_shift_reg
  import shift_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           dir,
  input  logic           load_valid,
  input  logic [MSB-1:0] load_data,
  output logic           load_ready,
  output logic           sout,
  output logic           sout_valid,
  output logic           last,
  output logic           busy
);

  localparam int                CW       = CNT_W(MSB);
  localparam logic [CW-1:0]     CNT_INIT = CW'(MSB - 1);

  state_e         state_q;
  state_e         state_d;
  logic [MSB-1:0] sreg_q;
  logic [MSB-1:0] sreg_d;
  logic           dir_q;
  logic           dir_d;

  logic           cnt_load;
  logic           cnt_dec;
  logic           cnt_zero;

  logic           in_shift;
  logic           final_bit;
  logic           accept;

  bit_cnt #(
    .W (CW)
  ) u_bit_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_shift  = (state_q == ST_SHIFT);
  // The final bit is consumed this edge; the slot can take a new word with no bubble.
  assign final_bit = in_shift && cnt_zero && en;

  assign load_ready = rstn && (!in_shift || final_bit);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    dir_d    = dir_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (in_shift && en) begin
      sreg_d = (dir_q == DIR_LSB_FIRST) ? (sreg_q >> 1) : (sreg_q << 1);
      if (cnt_zero) begin
        state_d = ST_IDLE;
      end else begin
        cnt_dec = 1'b1;
      end
    end

    // A handshake overrides the shift/exit above: in IDLE it starts a word,
    // on the final bit it chains the next word straight into SHIFT.
    if (accept) begin
      sreg_d   = load_data;
      dir_d    = dir;
      state_d  = ST_SHIFT;
      cnt_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
    end
  end

  // Outputs come straight from flops, gated by state, so a stall holds them.
  assign sout_valid = in_shift;
  assign busy       = in_shift;
  assign last       = in_shift && cnt_zero;
  assign sout       = in_shift && ((dir_q == DIR_LSB_FIRST) ? sreg_q[0] : sreg_q[MSB-1]);

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: a directed vector table, hand-written corner sequences and random traffic.
// Every cycle is also compared against a queue-of-pending-bits reference model.
module tb_piso_shift_reg;

  localparam int W = 16;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         dir;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;

  piso_shift_reg #(.MSB(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .dir        (dir),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the bits still to be sent, in transmit order.
  logic model_q[$];

  // Values observed at the most recent sample point.
  logic obs_sout, obs_vld, obs_last, obs_busy, obs_rdy;

  // Loopback receiver: a 16-bit serial-in register.
  logic [W-1:0] sipo;
  logic         lb_dir;
  logic         lb_on;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [W-1:0] w, input logic d);
    for (int i = 0; i < W; i++) begin
      model_q.push_back(d ? w[i] : w[W-1-i]);
    end
  endtask

  // One clock: apply inputs, check outputs against the model mid-cycle, then advance.
  task automatic drive(input logic r, input logic e, input logic d,
                       input logic lv, input logic [W-1:0] ld);
    logic m_vld, m_sout, m_last, m_rdy;
    rstn = r; en = e; dir = d; load_valid = lv; load_data = ld;
    @(negedge clk);
    m_vld  = (model_q.size() != 0);
    m_sout = m_vld ? model_q[0] : 1'b0;
    m_last = (model_q.size() == 1);
    m_rdy  = r && ((model_q.size() == 0) || ((model_q.size() == 1) && e));
    obs_sout = sout; obs_vld = sout_valid; obs_last = last;
    obs_busy = busy; obs_rdy = load_ready;
    chk("sout",       {31'd0, sout},       {31'd0, m_sout});
    chk("sout_valid", {31'd0, sout_valid}, {31'd0, m_vld});
    chk("last",       {31'd0, last},       {31'd0, m_last});
    chk("busy",       {31'd0, busy},       {31'd0, m_vld});
    chk("load_ready", {31'd0, load_ready}, {31'd0, m_rdy});
    @(posedge clk);
    if (lb_on && obs_vld && e) begin
      sipo = lb_dir ? {obs_sout, sipo[W-1:1]} : {sipo[W-2:0], obs_sout};
    end
    if (!r) begin
      model_q.delete();
    end else if (model_q.size() == 0) begin
      if (lv) model_push(ld, d);
    end else if (e) begin
      void'(model_q.pop_front());
      if ((model_q.size() == 0) && lv) model_push(ld, d);
    end
    #1;
  endtask

  typedef struct {
    logic         rstn;
    logic         en;
    logic         dir;
    logic         lv;
    logic [W-1:0] data;
    logic         e_sout;
    logic         e_vld;
    logic         e_last;
    logic         e_busy;
    logic         e_rdy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_bits;
    int n_vld, n_rdy, n_ones, last_idx, en_idx, n_last;

    lb_on = 1'b0; lb_dir = 1'b0; sipo = '0;
    rstn = 1'b0; en = 1'b0; dir = 1'b0; load_valid = 1'b0; load_data = '0;
    @(posedge clk); #1;

    // ---- Tests 1 and 2: reset, then MSB-first A5C3 from a vector table ----
    exp_bits = 16'b1010010111000011;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < W; i++) begin
      tbl[3+i] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000,
                   exp_bits[W-1-i], 1'b1, (i == W-1), 1'b1, (i == W-1)};
    end
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rstn, tbl[i].en, tbl[i].dir, tbl[i].lv, tbl[i].data);
      chk($sformatf("tbl%0d_sout", i), {31'd0, obs_sout}, {31'd0, tbl[i].e_sout});
      chk($sformatf("tbl%0d_vld",  i), {31'd0, obs_vld},  {31'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d_last", i), {31'd0, obs_last}, {31'd0, tbl[i].e_last});
      chk($sformatf("tbl%0d_busy", i), {31'd0, obs_busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_rdy",  i), {31'd0, obs_rdy},  {31'd0, tbl[i].e_rdy});
    end

    // ---- Test 3: LSB-first 0001 with en toggling ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0001);   // load completes even with en=0
    n_ones = 0; last_idx = -1; en_idx = 0; n_last = 0;
    for (int i = 0; i < 2*W; i++) begin
      drive(1'b1, (i % 2 == 0), 1'b0, 1'b0, 16'h0000);
      if (en && obs_vld) begin
        if (obs_sout) n_ones++;
        if (en_idx == 0) chk("lsb_first_bit", {31'd0, obs_sout}, 32'd1);
        if (obs_last) begin
          last_idx = en_idx;
          n_last++;
        end
        en_idx++;
      end
    end
    chk("lsb_ones",     n_ones,   1);
    chk("lsb_last_pos", last_idx, W-1);
    chk("lsb_last_cnt", n_last,   1);
    chk("lsb_en_bits",  en_idx,   W);

    // ---- Test 4: back-to-back FFFF then 0000 ----
    n_vld = 0; n_rdy = 0;
    for (int i = 0; i <= 2*W + 1; i++) begin
      drive(1'b1, 1'b1, 1'b0, (i <= W), (i == 0) ? 16'hFFFF : 16'h0000);
      if (i >= 1 && i <= 2*W) begin
        if (obs_vld) n_vld++;
        if (obs_rdy) n_rdy++;
      end
    end
    chk("b2b_valid_cycles", n_vld, 2*W);
    chk("b2b_ready_cycles", n_rdy, 2);
    chk("b2b_idle_after",   {31'd0, obs_vld}, 32'd0);

    // ---- Test 5: reset mid-word, then a clean 8000 ----
    n_last = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (obs_last) n_last++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("rst_mid_rdy", {31'd0, obs_rdy}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h8000);
    chk("rst_mid_vld", {31'd0, obs_vld}, 32'd0);
    chk("rst_mid_last_seen", n_last, 0);
    for (int i = 0; i < W + 1; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (i == 0) chk("w8000_first", {31'd0, obs_sout}, 32'd1);
    end

    // ---- Test 6: loopback into a serial-in register, both directions ----
    for (int d = 0; d < 2; d++) begin
      lb_dir = d[0]; sipo = '0; lb_on = 1'b1;
      drive(1'b1, 1'b1, d[0], 1'b1, 16'hBEEF);
      for (int i = 0; i < W + 1; i++) begin
        drive(1'b1, 1'b1, ~d[0], 1'b0, 16'h0000);
      end
      lb_on = 1'b0;
      chk($sformatf("loopback_dir%0d", d), {16'd0, sipo}, 32'h0000BEEF);
    end

    // ---- Random traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(3) != 0), $urandom_range(1),
            $urandom_range(1), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
